// File: rtl/vga_game_pkg.sv
// Shared constants for the VGA sprite game: 800x600@40MHz timing, direction
// encoding, operating modes and the sprite colour palette.
package vga_game_pkg;

  localparam int PIXEL_CLK_HZ  = 40_000_000;
  localparam int VGA_H_ACTIVE  = 800;
  localparam int VGA_H_FRONT   = 40;
  localparam int VGA_H_SYNC    = 128;
  localparam int VGA_H_BACK    = 88;
  localparam int VGA_H_TOTAL   = 1056;
  localparam int VGA_V_ACTIVE  = 600;
  localparam int VGA_V_FRONT   = 1;
  localparam int VGA_V_SYNC    = 4;
  localparam int VGA_V_BACK    = 23;
  localparam int VGA_V_TOTAL   = 628;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_BOUNCE = 1'b1
  } mode_e;

  localparam logic [7:0] PALETTE [8] = '{
    8'hFF, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'h92
  };

endpackage

// File: rtl/block_axis_mover.sv
// One axis of sprite motion: manual stepping or wall bounce, updated once per
// frame. Position is clamped to [0, LIMIT]; hit flags a bounce at either wall.
module block_axis_mover
  import vga_game_pkg::*;
#(
  parameter int LIMIT   = 760,
  parameter int STEP    = 8,
  parameter int COORD_W = 10,
  parameter int SPEED_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_neg,
  input  logic               key_pos,
  input  logic               mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               update,
  output logic [COORD_W-1:0] pos,
  output logic               hit
);

  localparam int AW = COORD_W + 2;
  typedef logic signed [AW-1:0] acc_t;
  localparam acc_t LIM = acc_t'(LIMIT);
  localparam acc_t STP = acc_t'(STEP);

  logic               dir;
  logic               dir_next;
  logic [COORD_W-1:0] pos_next;
  logic               at_low;
  logic               at_high;
  acc_t               delta;
  acc_t               sum;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    dir_next = dir;
    delta    = '0;
    pos_next = pos;
    at_low   = 1'b0;
    at_high  = 1'b0;
    hit      = 1'b0;

    if (mode_e'(mode) == MODE_MANUAL) begin
      if (key_pos && !key_neg)      delta = STP;
      else if (key_neg && !key_pos) delta = -STP;
    end else begin
      // A pending key steers the direction before this frame's step.
      if (key_neg && !key_pos)      dir_next = DIR_NEG;
      else if (key_pos && !key_neg) dir_next = DIR_POS;
      delta = (dir_next == DIR_NEG) ? -acc_t'(speed) : acc_t'(speed);
    end

    sum = acc_t'(pos) + delta;
    if (sum <= 0) begin
      pos_next = '0;
      at_low   = 1'b1;
    end else if (sum >= LIM) begin
      pos_next = COORD_W'(LIMIT);
      at_high  = 1'b1;
    end else begin
      pos_next = sum[COORD_W-1:0];
    end

    // A frozen sprite resting on a wall is not a bounce.
    if (mode_e'(mode) == MODE_BOUNCE && speed != '0) begin
      if (at_low) begin
        dir_next = DIR_POS;
        hit      = update;
      end else if (at_high) begin
        dir_next = DIR_NEG;
        hit      = update;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= COORD_W'(LIMIT / 2);
      dir <= DIR_POS;
    end else if (update) begin
      pos <= pos_next;
      dir <= dir_next;
    end
  end

endmodule

// File: rtl/block_mover_ctrl.sv
// Moves one rectangular sprite around the visible screen, once per frame, and
// paints it into the pixel stream with one cycle of latency.
module block_mover_ctrl
  import vga_game_pkg::*;
#(
  parameter int         H_ACTIVE  = VGA_H_ACTIVE,
  parameter int         V_ACTIVE  = VGA_V_ACTIVE,
  parameter int         COORD_W   = 10,
  parameter int         BLK_W     = 40,
  parameter int         BLK_H     = 40,
  parameter int         STEP      = 8,
  parameter int         SPEED_W   = 3,
  parameter logic [7:0] BG_COLOUR = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic [COORD_W-1:0] vga_xide,
  input  logic [COORD_W-1:0] vga_yide,
  output logic [7:0]         vga_data,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [15:0]        wall_hits,
  output logic               hit_pulse
);

  logic pend_left, pend_right, pend_up, pend_down;
  logic eff_left, eff_right, eff_up, eff_down;
  logic hit_x, hit_y, hit_event;
  logic [2:0] colour_idx;
  logic in_blk;

  // A press in the frame_start cycle itself still counts for this update.
  assign eff_left  = pend_left  | key_left;
  assign eff_right = pend_right | key_right;
  assign eff_up    = pend_up    | key_up;
  assign eff_down  = pend_down  | key_down;

  block_axis_mover #(
    .LIMIT(H_ACTIVE - BLK_W), .STEP(STEP), .COORD_W(COORD_W), .SPEED_W(SPEED_W)
  ) u_axis_x (
    .clk(clk), .rst(rst), .key_neg(eff_left), .key_pos(eff_right), .mode(mode),
    .speed(speed), .update(frame_start), .pos(pos_x), .hit(hit_x)
  );

  block_axis_mover #(
    .LIMIT(V_ACTIVE - BLK_H), .STEP(STEP), .COORD_W(COORD_W), .SPEED_W(SPEED_W)
  ) u_axis_y (
    .clk(clk), .rst(rst), .key_neg(eff_up), .key_pos(eff_down), .mode(mode),
    .speed(speed), .update(frame_start), .pos(pos_y), .hit(hit_y)
  );

  // A corner bounce touches both walls but is a single event.
  assign hit_event = hit_x | hit_y;

  // One extra bit keeps pos+BLK from wrapping at the right and bottom edges.
  assign in_blk = ({1'b0, vga_xide} >= {1'b0, pos_x}) &&
                  ({1'b0, vga_xide} <  {1'b0, pos_x} + (COORD_W+1)'(BLK_W)) &&
                  ({1'b0, vga_yide} >= {1'b0, pos_y}) &&
                  ({1'b0, vga_yide} <  {1'b0, pos_y} + (COORD_W+1)'(BLK_H));

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_up    <= 1'b0;
      pend_down  <= 1'b0;
      hit_pulse  <= 1'b0;
      wall_hits  <= '0;
      colour_idx <= '0;
      vga_data   <= BG_COLOUR;
    end else begin
      // NOTE: non-blocking updates keep every register reading last cycle's values.
      pend_left  <= frame_start ? 1'b0 : eff_left;
      pend_right <= frame_start ? 1'b0 : eff_right;
      pend_up    <= frame_start ? 1'b0 : eff_up;
      pend_down  <= frame_start ? 1'b0 : eff_down;
      hit_pulse  <= hit_event;
      if (hit_event) begin
        colour_idx <= colour_idx + 3'd1;
        if (wall_hits != 16'hFFFF) wall_hits <= wall_hits + 16'd1;
      end
      vga_data <= in_blk ? PALETTE[colour_idx] : BG_COLOUR;
    end
  end

endmodule

// File: tb/tb_block_mover_ctrl.sv
// Self-checking bench for block_mover_ctrl: directed scenarios plus randomized
// traffic against a frame-level behavioural model of the sprite.
module tb_block_mover_ctrl;
  import vga_game_pkg::*;

  localparam int LIM_X   = 760;
  localparam int LIM_Y   = 560;
  localparam int STEP_PX = 8;
  localparam int BLK     = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [9:0] vga_xide = '0, vga_yide = '0;
  logic [7:0] vga_data;
  logic [9:0] pos_x, pos_y;
  logic [15:0] wall_hits;
  logic       hit_pulse;

  logic       fs_s = 1'b0;
  logic [7:0] vga_data_s;
  logic [3:0] pos_x_s, pos_y_s;
  logic [15:0] wall_hits_s;
  logic       hit_pulse_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference model of the main instance.
  int m_x, m_y, m_dx, m_dy, m_c, m_hits;
  bit m_pulse;
  bit p_l, p_r, p_u, p_d;
  logic [7:0] m_pix;

  always #5 clk = ~clk;

  block_mover_ctrl dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .mode(mode), .speed(speed), .vga_xide(vga_xide), .vga_yide(vga_yide),
    .vga_data(vga_data), .pos_x(pos_x), .pos_y(pos_y),
    .wall_hits(wall_hits), .hit_pulse(hit_pulse)
  );

  // Tiny screen where a speed-7 sprite bounces off a wall every frame.
  block_mover_ctrl #(
    .H_ACTIVE(15), .V_ACTIVE(15), .COORD_W(4), .BLK_W(8), .BLK_H(8),
    .STEP(2), .SPEED_W(3), .BG_COLOUR(8'h00)
  ) dut_small (
    .clk(clk), .rst(rst), .frame_start(fs_s),
    .key_left(1'b0), .key_right(1'b0), .key_up(1'b0), .key_down(1'b0),
    .mode(1'b1), .speed(3'd7), .vga_xide(4'd0), .vga_yide(4'd0),
    .vga_data(vga_data_s), .pos_x(pos_x_s), .pos_y(pos_y_s),
    .wall_hits(wall_hits_s), .hit_pulse(hit_pulse_s)
  );

  function automatic void axis_model(inout int p, inout int d, input int lim,
                                     input bit kn, input bit kp, input bit bounce,
                                     input int spd, output bit hit);
    hit = 1'b0;
    if (!bounce) begin
      p = p + STEP_PX * (int'(kp) - int'(kn));
      if (p < 0) p = 0;
      if (p > lim) p = lim;
    end else begin
      if (kn && !kp) d = -1;
      else if (kp && !kn) d = 1;
      if (spd != 0) begin
        p = p + d * spd;
        if (p <= 0) begin p = 0; d = 1; hit = 1'b1; end
        else if (p >= lim) begin p = lim; d = -1; hit = 1'b1; end
      end
    end
  endfunction

  task automatic model_reset();
    m_x = 380; m_y = 280; m_dx = 1; m_dy = 1; m_c = 0; m_hits = 0;
    m_pulse = 1'b0; p_l = 0; p_r = 0; p_u = 0; p_d = 0; m_pix = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
  endtask

  // One clock with the given frame/key pulses; the model advances alongside.
  task automatic step(input bit fs, input bit kl, input bit kr, input bit ku, input bit kd);
    bit l, r, u, d, hx, hy;
    frame_start = fs; key_left = kl; key_right = kr; key_up = ku; key_down = kd;
    @(posedge clk);
    if (int'(vga_xide) >= m_x && int'(vga_xide) < m_x + BLK &&
        int'(vga_yide) >= m_y && int'(vga_yide) < m_y + BLK) m_pix = PALETTE[m_c];
    else m_pix = 8'h00;
    l = p_l | kl; r = p_r | kr; u = p_u | ku; d = p_d | kd;
    m_pulse = 1'b0;
    if (fs) begin
      axis_model(m_x, m_dx, LIM_X, l, r, mode, int'(speed), hx);
      axis_model(m_y, m_dy, LIM_Y, u, d, mode, int'(speed), hy);
      if (mode && (hx || hy)) begin
        m_pulse = 1'b1;
        m_c = (m_c + 1) % 8;
        if (m_hits < 65535) m_hits++;
      end
      p_l = 0; p_r = 0; p_u = 0; p_d = 0;
    end else begin
      p_l = l; p_r = r; p_u = u; p_d = d;
    end
    #1;
    frame_start = 1'b0; key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pos_x !== 10'd380) begin n_fail++; $display("FAIL reset_pos_x: got %0d want 380", pos_x); end
    n_checks++; if (pos_y !== 10'd280) begin n_fail++; $display("FAIL reset_pos_y: got %0d want 280", pos_y); end
    n_checks++; if (vga_data !== 8'h00) begin n_fail++; $display("FAIL reset_vga_data: got %h want 00", vga_data); end
    n_checks++; if (wall_hits !== 16'd0) begin n_fail++; $display("FAIL reset_wall_hits: got %0d want 0", wall_hits); end
    n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_hit_pulse: got %b want 0", hit_pulse); end
  endtask

  task automatic test_manual();
    bit saw_pulse = 1'b0;
    mode = 1'b0; speed = 3'd0;
    repeat (3) step(0, 0, 1, 0, 0);
    n_checks++; if (pos_x !== 10'd380) begin n_fail++; $display("FAIL manual_hold_until_frame: got %0d want 380", pos_x); end
    step(1, 0, 0, 0, 0);
    n_checks++; if (pos_x !== 10'd388) begin n_fail++; $display("FAIL manual_triple_press: got %0d want 388", pos_x); end
    n_checks++; if (pos_y !== 10'd280) begin n_fail++; $display("FAIL manual_y_still: got %0d want 280", pos_y); end
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      saw_pulse |= hit_pulse;
    end
    n_checks++; if (pos_x !== 10'd760) begin n_fail++; $display("FAIL manual_saturate_x: got %0d want 760", pos_x); end
    n_checks++; if (saw_pulse !== 1'b0 || wall_hits !== 16'd0) begin
      n_fail++; $display("FAIL manual_no_hits: got pulse %b hits %0d want 0 0", saw_pulse, wall_hits);
    end
  endtask

  task automatic test_cancel_and_coincident();
    step(0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    n_checks++; if (pos_x !== 10'd760) begin n_fail++; $display("FAIL cancel_x: got %0d want 760", pos_x); end
    n_checks++; if (pos_y !== 10'd280) begin n_fail++; $display("FAIL cancel_y: got %0d want 280", pos_y); end
    step(1, 1, 0, 0, 0);
    n_checks++; if (pos_x !== 10'd752) begin n_fail++; $display("FAIL coincident_key: got %0d want 752", pos_x); end
    step(1, 0, 0, 0, 0);
    n_checks++; if (pos_x !== 10'd752) begin n_fail++; $display("FAIL pending_cleared: got %0d want 752", pos_x); end
  endtask

  task automatic test_bounce_hit();
    do_reset();
    mode = 1'b0;
    for (int i = 0; i < 47; i++) begin
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
    end
    n_checks++; if (pos_x !== 10'd756) begin n_fail++; $display("FAIL bounce_setup_x: got %0d want 756", pos_x); end
    mode = 1'b1; speed = 3'd7;
    vga_xide = 10'd770; vga_yide = 10'd300;
    step(1, 0, 0, 0, 0);
    n_checks++; if (pos_x !== 10'd760) begin n_fail++; $display("FAIL bounce_clamp_x: got %0d want 760", pos_x); end
    n_checks++; if (pos_y !== 10'd287) begin n_fail++; $display("FAIL bounce_step_y: got %0d want 287", pos_y); end
    n_checks++; if (hit_pulse !== 1'b1) begin n_fail++; $display("FAIL bounce_hit_pulse: got %b want 1", hit_pulse); end
    n_checks++; if (wall_hits !== 16'd1) begin n_fail++; $display("FAIL bounce_wall_hits: got %0d want 1", wall_hits); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL bounce_pulse_width: got %b want 0", hit_pulse); end
    n_checks++; if (vga_data !== 8'hE0) begin n_fail++; $display("FAIL bounce_colour_idx1: got %h want e0", vga_data); end
    step(1, 0, 0, 0, 0);
    n_checks++; if (pos_x !== 10'd753) begin n_fail++; $display("FAIL bounce_reversed: got %0d want 753", pos_x); end
  endtask

  task automatic test_corner_and_frozen();
    mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 0);
    end
    mode = 1'b1; speed = 3'd3;
    step(1, 1, 0, 1, 0);
    n_checks++; if (pos_x !== 10'd757 || pos_y !== 10'd557) begin
      n_fail++; $display("FAIL corner_setup: got (%0d,%0d) want (757,557)", pos_x, pos_y);
    end
    speed = 3'd5;
    step(1, 0, 1, 0, 1);
    n_checks++; if (pos_x !== 10'd760 || pos_y !== 10'd560) begin
      n_fail++; $display("FAIL corner_clamp: got (%0d,%0d) want (760,560)", pos_x, pos_y);
    end
    n_checks++; if (wall_hits !== 16'd2) begin n_fail++; $display("FAIL corner_single_event: got %0d want 2", wall_hits); end
    speed = 3'd0;
    step(1, 0, 1, 0, 1);
    n_checks++; if (pos_x !== 10'd760 || pos_y !== 10'd560 || hit_pulse !== 1'b0 || wall_hits !== 16'd2) begin
      n_fail++; $display("FAIL speed0_frozen: got (%0d,%0d) pulse %b hits %0d want (760,560) 0 2",
                         pos_x, pos_y, hit_pulse, wall_hits);
    end
  endtask

  task automatic test_pixel_and_reset();
    int px [6] = '{100, 139,  99, 140, 100, 139};
    int py [6] = '{ 50,  89,  50,  50,  49,  90};
    logic [7:0] want [6] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    mode = 1'b0;
    for (int i = 0; i < 35; i++) begin
      step(0, 1, 0, (i < 29), 0);
      step(1, 0, 0, 0, 0);
    end
    mode = 1'b1; speed = 3'd1;
    step(1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 0);
    n_checks++; if (pos_x !== 10'd100 || pos_y !== 10'd50) begin
      n_fail++; $display("FAIL pixel_setup: got (%0d,%0d) want (100,50)", pos_x, pos_y);
    end
    for (int i = 0; i < 6; i++) begin
      vga_xide = 10'(px[i]); vga_yide = 10'(py[i]);
      step(0, 0, 0, 0, 0);
      n_checks++; if (vga_data !== want[i]) begin
        n_fail++; $display("FAIL pixel_%0d_%0d: got %h want %h", px[i], py[i], vga_data, want[i]);
      end
    end
    vga_xide = 10'd100; vga_yide = 10'd50;
    @(negedge clk);
    n_checks++; if (vga_data !== 8'h00) begin n_fail++; $display("FAIL pixel_latency: got %h want 00", vga_data); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (vga_data !== 8'hFF) begin n_fail++; $display("FAIL pixel_after_latency: got %h want ff", vga_data); end
    do_reset();
    n_checks++; if (pos_x !== 10'd380 || pos_y !== 10'd280 || vga_data !== 8'h00) begin
      n_fail++; $display("FAIL midframe_reset: got (%0d,%0d) %h want (380,280) 00", pos_x, pos_y, vga_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit fs;
      fs = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) mode = ($urandom_range(9) < 7);
      if (fs) speed = 3'($urandom_range(7));
      if ($urandom_range(1) == 1) begin
        vga_xide = 10'($urandom_range(799)); vga_yide = 10'($urandom_range(599));
      end else begin
        vga_xide = 10'(m_x + $urandom_range(41)); vga_yide = 10'(m_y + $urandom_range(41));
      end
      step(fs, ($urandom_range(7) == 0), ($urandom_range(7) == 0),
               ($urandom_range(7) == 0), ($urandom_range(7) == 0));
      n_checks++; if (pos_x !== 10'(m_x) || pos_y !== 10'(m_y)) begin
        n_fail++; $display("FAIL rand_pos @%0d: got (%0d,%0d) want (%0d,%0d)", i, pos_x, pos_y, m_x, m_y);
      end
      n_checks++; if (hit_pulse !== m_pulse || wall_hits !== 16'(m_hits)) begin
        n_fail++; $display("FAIL rand_hits @%0d: got pulse %b hits %0d want %b %0d", i, hit_pulse, wall_hits, m_pulse, m_hits);
      end
      n_checks++; if (vga_data !== m_pix) begin
        n_fail++; $display("FAIL rand_pixel @%0d: got %h want %h", i, vga_data, m_pix);
      end
    end
  endtask

  task automatic test_saturate();
    fs_s = 1'b1;
    for (int k = 1; k <= 65540; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_checks++; if (pos_x_s !== 4'd7 || wall_hits_s !== 16'd1) begin
          n_fail++; $display("FAIL small_first_hit: got pos %0d hits %0d want 7 1", pos_x_s, wall_hits_s);
        end
      end
      if (k == 100) begin
        n_checks++; if (wall_hits_s !== 16'd100) begin n_fail++; $display("FAIL small_count_100: got %0d want 100", wall_hits_s); end
      end
      if (k == 65534) begin
        n_checks++; if (wall_hits_s !== 16'hFFFE) begin n_fail++; $display("FAIL small_pre_sat: got %h want fffe", wall_hits_s); end
      end
    end
    n_checks++; if (wall_hits_s !== 16'hFFFF || hit_pulse_s !== 1'b1) begin
      n_fail++; $display("FAIL saturate: got hits %h pulse %b want ffff 1", wall_hits_s, hit_pulse_s);
    end
    fs_s = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (hit_pulse_s !== 1'b0 || wall_hits_s !== 16'hFFFF) begin
      n_fail++; $display("FAIL saturate_idle: got hits %h pulse %b want ffff 0", wall_hits_s, hit_pulse_s);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_manual();
    test_cancel_and_coincident();
    test_bounce_hit();
    test_corner_and_frozen();
    test_pixel_and_reset();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
